// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared segment type, active-low gfedcba glyph constants and hex decode function
// Contents: seg_t, SEG_BLANK, SEG_0..SEG_F, hex_to_seg(nibble, hex_en)
package sevenseg_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_0 = 7'b1000000;
    localparam seg_t SEG_1 = 7'b1111001;
    localparam seg_t SEG_2 = 7'b0100100;
    localparam seg_t SEG_3 = 7'b0110000;
    localparam seg_t SEG_4 = 7'b0011001;
    localparam seg_t SEG_5 = 7'b0010010;
    localparam seg_t SEG_6 = 7'b0000010;
    localparam seg_t SEG_7 = 7'b1111000;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0010000;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b0000011;
    localparam seg_t SEG_C = 7'b1000110;
    localparam seg_t SEG_D = 7'b0100001;
    localparam seg_t SEG_E = 7'b0000110;
    localparam seg_t SEG_F = 7'b0001110;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble, input logic hex_en);
        seg_t s;
        case (nibble)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return (nibble > 4'd9 && !hex_en) ? SEG_BLANK : s;
    endfunction
endpackage

// File: rtl/sevenseg_hex_decoder.sv
// sevenseg_hex_decoder: combinational nibble to active-low seven-segment glyph
// Ports: i_nibble (4-bit value), o_seg (gfedcba, 0 = lit); HEX_EN=0 blanks codes 10-15
module sevenseg_hex_decoder
    import sevenseg_pkg::*;
#(
    parameter int HEX_EN = 1
) (
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);
    assign o_seg = hex_to_seg(i_nibble, HEX_EN != 0);
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed N-digit seven-segment driver with frame-synchronous updates
// Ports: clk, rst_n (async active-low); digits_i/dp_i/blank_i/lzs_en captured on load;
//        segments_o/dp_o active-low, an_o per-digit enables, frame_done pulse at scan wrap
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_CYC     = 16,
    parameter int HEX_EN        = 1,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    input  logic                  lzs_en,
    input  logic                  load,
    output seg_t                  segments_o,
    output logic                  dp_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    // XOR mask: the inactive anode level, also turns a one-hot into the right polarity
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW != 0}};

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [4*N_DIGITS-1:0] r_pend_dig, r_act_dig;
    logic [N_DIGITS-1:0]   r_pend_dp, r_act_dp;
    logic [N_DIGITS-1:0]   r_pend_bl, r_act_bl;
    logic                  r_pend_lzs, r_act_lzs;
    logic                  r_pend_v;
    logic                  r_wrapped;

    logic                  w_slot_end;
    logic                  w_bound;
    logic [3:0]            w_nib;
    seg_t                  w_seg;
    logic [N_DIGITS-1:0]   w_dark;
    logic                  w_dark_cur;
    logic [N_DIGITS-1:0]   w_an;

    assign w_slot_end = r_cnt == CW'(REFRESH_DIV - 1);
    assign w_bound    = w_slot_end && r_idx == IW'(N_DIGITS - 1);
    assign w_nib      = r_act_dig[{r_idx, 2'b00} +: 4];
    assign w_dark_cur = w_dark[r_idx];
    assign w_an       = int'(r_cnt) >= BLANK_CYC ? ((N_DIGITS'(1) << r_idx) ^ AN_OFF) : AN_OFF;

    // Walk from the most significant digit down; a digit is suppressed while all digits
    // at and above it are zero, except digit 0 which always shows.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        w_dark   = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            all_zero  = all_zero && (r_act_dig[4*k +: 4] == 4'd0);
            w_dark[k] = r_act_bl[k] || (r_act_lzs && all_zero && k != 0);
        end
    end

    sevenseg_hex_decoder #(.HEX_EN(HEX_EN)) u_dec (
        .i_nibble(w_nib),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_pend_dig <= '0;
            r_pend_dp  <= '0;
            r_pend_bl  <= '0;
            r_pend_lzs <= 1'b0;
            r_pend_v   <= 1'b0;
            r_act_dig  <= '0;
            r_act_dp   <= '0;
            r_act_bl   <= '0;
            r_act_lzs  <= 1'b0;
            r_wrapped  <= 1'b0;
            segments_o <= SEG_BLANK;
            dp_o       <= 1'b1;
            an_o       <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end)
                r_idx <= w_bound ? '0 : r_idx + 1'b1;
            if (load) begin
                r_pend_dig <= digits_i;
                r_pend_dp  <= dp_i;
                r_pend_bl  <= blank_i;
                r_pend_lzs <= lzs_en;
            end
            r_pend_v <= !w_bound && (r_pend_v || load);
            // A load landing on the boundary bypasses pending so it is the value committed
            if (w_bound && (load || r_pend_v)) begin
                r_act_dig <= load ? digits_i : r_pend_dig;
                r_act_dp  <= load ? dp_i : r_pend_dp;
                r_act_bl  <= load ? blank_i : r_pend_bl;
                r_act_lzs <= load ? lzs_en : r_pend_lzs;
            end
            // Delayed twice so the pulse lines up with the registered first output of digit 0
            r_wrapped  <= w_bound;
            frame_done <= r_wrapped;
            segments_o <= w_dark_cur ? SEG_BLANK : w_seg;
            dp_o       <= w_dark_cur || !r_act_dp[r_idx];
            an_o       <= w_an;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: scoreboard bench for sevenseg_scan (HEX_EN=1 and HEX_EN=0 instances)
module tb_sevenseg_scan;
    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        lzs;
    } ld_t;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0][6:0] seg_nh;
        logic [3:0]      dp;
    } exp_t;

    logic        clk, rst_n, lzs_en, load;
    logic [15:0] digits;
    logic [3:0]  dp_in, blank;
    logic [6:0]  seg, seg_nh;
    logic        dp_o, dp_nh, fd, fd_nh;
    logic [3:0]  an, an_nh;

    int   n_err = 0;
    int   n_chk = 0;
    int   frame_no = 0;
    exp_t sb[$];
    exp_t e;
    ld_t  cur, pend;
    bit   pend_v;
    ld_t  vals[6];

    sevenseg_scan #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .HEX_EN(1), .AN_ACTIVE_LOW(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits), .dp_i(dp_in), .blank_i(blank),
        .lzs_en(lzs_en), .load(load), .segments_o(seg), .dp_o(dp_o), .an_o(an), .frame_done(fd)
    );

    sevenseg_scan #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .HEX_EN(0), .AN_ACTIVE_LOW(1)) u_dut_nh (
        .clk(clk), .rst_n(rst_n), .digits_i(digits), .dp_i(dp_in), .blank_i(blank),
        .lzs_en(lzs_en), .load(load), .segments_o(seg_nh), .dp_o(dp_nh), .an_o(an_nh), .frame_done(fd_nh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n, input bit hex);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return hex ? 7'b0001000 : 7'h7F;
            4'hB: return hex ? 7'b0000011 : 7'h7F;
            4'hC: return hex ? 7'b1000110 : 7'h7F;
            4'hD: return hex ? 7'b0100001 : 7'h7F;
            4'hE: return hex ? 7'b0000110 : 7'h7F;
            default: return hex ? 7'b0001110 : 7'h7F;
        endcase
    endfunction

    function automatic exp_t mk_exp(input ld_t v);
        exp_t x;
        bit   z;
        bit   dark;
        z = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            z = z && (v.dig[4*k +: 4] == 4'd0);
            dark = v.bl[k] || (v.lzs && z && k != 0);
            x.seg[k]    = dark ? 7'h7F : ref_seg(v.dig[4*k +: 4], 1'b1);
            x.seg_nh[k] = dark ? 7'h7F : ref_seg(v.dig[4*k +: 4], 1'b0);
            x.dp[k]     = dark ? 1'b1 : ~v.dp[k];
        end
        return x;
    endfunction

    task automatic drive(input ld_t v);
        digits = v.dig;
        dp_in  = v.dp;
        blank  = v.bl;
        lzs_en = v.lzs;
        load   = 1'b1;
        pend   = v;
        pend_v = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " seg"}, seg, 7'h7F);
        chk({tag, " dp"}, dp_o, 1'b1);
        chk({tag, " an"}, an, 4'hF);
        chk({tag, " fd"}, fd, 1'b0);
    endtask

    task automatic restart();
        rst_n  = 1'b1;
        cur    = '0;
        pend_v = 1'b0;
        sb.delete();
        sb.push_back(mk_exp(cur));
    endtask

    // One 16-cycle frame: j=0 is the output cycle carrying frame_done; loads at ja/jb; reset at rj
    task automatic run_frame(input bit first, input int ja, input int va, input int jb, input int vb, input int rj);
        int slot, pos;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk($sformatf("f%0d sb_size", frame_no), sb.size(), 1);
                if (sb.size() > 0) e = sb.pop_front();
            end
            slot = j / 4;
            pos  = j % 4;
            chk($sformatf("f%0d j%0d an", frame_no, j), an, pos == 0 ? 4'hF : 4'hF ^ (4'b1 << slot));
            chk($sformatf("f%0d j%0d frame_done", frame_no, j), fd, j == 0 && !first);
            if (pos == 1) begin
                chk($sformatf("f%0d d%0d seg", frame_no, slot), seg, e.seg[slot]);
                chk($sformatf("f%0d d%0d seg_nohex", frame_no, slot), seg_nh, e.seg_nh[slot]);
                chk($sformatf("f%0d d%0d dp", frame_no, slot), dp_o, e.dp[slot]);
            end
            if (j == rj) begin
                rst_n = 1'b0;
                load  = 1'b0;
                #1;
                chk_reset("async_rst");
                @(negedge clk);
                chk_reset("rst_hold");
                restart();
                frame_no++;
                return;
            end
            if (j == 15) begin
                if (pend_v) begin
                    cur    = pend;
                    pend_v = 1'b0;
                end
                sb.push_back(mk_exp(cur));
            end
            load = 1'b0;
            if (j == ja) drive(vals[va]);
            else if (j == jb) drive(vals[vb]);
        end
        frame_no++;
    endtask

    initial begin
        vals[0] = '{dig: 16'h12AF, dp: 4'b0000, bl: 4'b0000, lzs: 1'b0};
        vals[1] = '{dig: 16'h0040, dp: 4'b0001, bl: 4'b0000, lzs: 1'b1};
        vals[2] = '{dig: 16'h1234, dp: 4'b1000, bl: 4'b0100, lzs: 1'b0};
        vals[3] = '{dig: 16'h1111, dp: 4'b0000, bl: 4'b0000, lzs: 1'b0};
        vals[4] = '{dig: 16'h2222, dp: 4'b0000, bl: 4'b0000, lzs: 1'b0};
        vals[5] = '{dig: 16'h12AF, dp: 4'b1010, bl: 4'b0000, lzs: 1'b0};
        rst_n  = 1'b0;
        digits = '0;
        dp_in  = '0;
        blank  = '0;
        lzs_en = 1'b0;
        load   = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        restart();
        run_frame(1, -1, 0, -1, 0, -1);
        run_frame(0,  5, 0, -1, 0, -1);
        run_frame(0,  3, 1, -1, 0, -1);
        run_frame(0,  8, 2, -1, 0, -1);
        run_frame(0,  6, 3, 14, 4, -1);
        run_frame(0, 15, 3, -1, 0, -1);
        run_frame(0,  3, 5, -1, 0,  9);
        run_frame(1, -1, 0, -1, 0, -1);
        run_frame(0, -1, 0, -1, 0, -1);
        run_frame(0, -1, 0, -1, 0, -1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
